// File: rtl/wb_pkg.sv
// Shared sizing constants for the writeback register file and its per-register
// pending-write scoreboard.
package wb_pkg;

   localparam int REG_W  = 8;
   localparam int NREG   = 8;
   localparam int ADR_W  = 3;
   localparam int PEND_W = 2;

   localparam logic [PEND_W-1:0] PEND_MAX = 2'd3;

   typedef logic [REG_W-1:0]  reg_data_t;
   typedef logic [ADR_W-1:0]  reg_adr_t;
   typedef logic [PEND_W-1:0] pend_cnt_t;

   // True when an address selects the hard-wired zero register.
   function automatic logic is_r0(input reg_adr_t adr);
      return (adr == '0);
   endfunction

endpackage

// File: rtl/wb_pend_cnt.sv
// Pending-write counter for one architectural register: counts issued writes that
// have not yet come back through writeback, and flags a writeback with nothing pending.
module wb_pend_cnt
   import wb_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      i_inc,
   input  logic      i_dec,
   output pend_cnt_t o_pend,
   output logic      o_uflow
);

   pend_cnt_t r_pend;

   logic w_up;
   logic w_down;

   assign w_up   = i_inc & ~i_dec;
   assign w_down = i_dec & ~i_inc;

   // An inc/dec pair in the same cycle nets to zero; the hold at PEND_MAX is
   // a guard only, since the issue stall already refuses a fourth write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend <= '0;
      end else if (w_up && (r_pend != PEND_MAX)) begin
         r_pend <= r_pend + 1'b1;
      end else if (w_down && (r_pend != '0)) begin
         r_pend <= r_pend - 1'b1;
      end
   end

   assign o_pend  = r_pend;
   assign o_uflow = w_down & (r_pend == '0);

endmodule

// File: rtl/wb_regfile.sv
// 8x8 register file with write-through bypass and a pending-write scoreboard that
// stalls issue on read-after-write hazards and on a fourth outstanding write.
module wb_regfile
   import wb_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] wb_result,
   input  logic [ADR_W-1:0] wb_dest,
   input  logic             wb_we,
   input  logic [ADR_W-1:0] rd_a_adr,
   input  logic [ADR_W-1:0] rd_b_adr,
   input  logic             rd_a_en,
   input  logic             rd_b_en,
   output logic [REG_W-1:0] rd_a_data,
   output logic [REG_W-1:0] rd_b_data,
   input  logic             iss_valid,
   input  logic             iss_we,
   input  logic [ADR_W-1:0] iss_dest,
   output logic             stall,
   output logic [NREG-1:0]  busy_vec,
   output logic             err_underflow
);

   reg_data_t r_regs [NREG];
   logic      r_err;

   pend_cnt_t         w_pend [NREG];
   logic [NREG-1:1]   w_inc;
   logic [NREG-1:1]   w_dec;
   logic [NREG-1:1]   w_uflow;
   logic [NREG-1:0]   w_eff_nz;
   logic [NREG-1:0]   w_full;
   logic              w_hz_a;
   logic              w_hz_b;
   logic              w_hz_full;
   logic              w_stall;

   assign w_pend[0]   = '0;
   assign w_eff_nz[0] = 1'b0;
   assign w_full[0]   = 1'b0;
   assign busy_vec[0] = 1'b0;

   for (genvar r = 1; r < NREG; r++) begin : g_pend
      assign w_dec[r] = wb_we & (wb_dest == ADR_W'(r));
      assign w_inc[r] = iss_valid & iss_we & ~w_stall & (iss_dest == ADR_W'(r));

      wb_pend_cnt u_pend_cnt (
         .clk     (clk),
         .rst     (rst),
         .i_inc   (w_inc[r]),
         .i_dec   (w_dec[r]),
         .o_pend  (w_pend[r]),
         .o_uflow (w_uflow[r])
      );

      // eff = pend - dec (floored) is nonzero exactly when pend exceeds dec.
      assign w_eff_nz[r] = (w_pend[r] > PEND_W'(w_dec[r]));
      assign w_full[r]   = (w_pend[r] == PEND_MAX) & ~w_dec[r];
      assign busy_vec[r] = (w_pend[r] != '0);
   end

   always_comb begin
      w_hz_a    = rd_a_en & ~is_r0(rd_a_adr) & w_eff_nz[rd_a_adr];
      w_hz_b    = rd_b_en & ~is_r0(rd_b_adr) & w_eff_nz[rd_b_adr];
      w_hz_full = iss_we  & ~is_r0(iss_dest) & w_full[iss_dest];
      w_stall   = iss_valid & (w_hz_a | w_hz_b | w_hz_full);
   end

   assign stall = w_stall;

   // r_regs[0] is reset and never written, so it is a constant zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (wb_we && !is_r0(wb_dest)) begin
         r_regs[wb_dest] <= wb_result;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (|w_uflow) begin
         r_err <= 1'b1;
      end
   end

   assign err_underflow = r_err;

   always_comb begin
      rd_a_data = r_regs[rd_a_adr];
      if (is_r0(rd_a_adr)) begin
         rd_a_data = '0;
      end else if (wb_we && (wb_dest == rd_a_adr)) begin
         rd_a_data = wb_result;
      end
   end

   always_comb begin
      rd_b_data = r_regs[rd_b_adr];
      if (is_r0(rd_b_adr)) begin
         rd_b_data = '0;
      end else if (wb_we && (wb_dest == rd_b_adr)) begin
         rd_b_data = wb_result;
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed hazard scenarios followed by random
// traffic, all compared against an array-based model of the register file.
module tb_wb_regfile;

   logic       clk;
   logic       rst;
   logic [7:0] wb_result;
   logic [2:0] wb_dest;
   logic       wb_we;
   logic [2:0] rd_a_adr;
   logic [2:0] rd_b_adr;
   logic       rd_a_en;
   logic       rd_b_en;
   logic [7:0] rd_a_data;
   logic [7:0] rd_b_data;
   logic       iss_valid;
   logic       iss_we;
   logic [2:0] iss_dest;
   logic       stall;
   logic [7:0] busy_vec;
   logic       err_underflow;

   int n_tests;
   int n_fail;

   int m_reg  [8];
   int m_pend [8];
   bit m_err;

   wb_regfile dut (
      .clk           (clk),
      .rst           (rst),
      .wb_result     (wb_result),
      .wb_dest       (wb_dest),
      .wb_we         (wb_we),
      .rd_a_adr      (rd_a_adr),
      .rd_b_adr      (rd_b_adr),
      .rd_a_en       (rd_a_en),
      .rd_b_en       (rd_b_en),
      .rd_a_data     (rd_a_data),
      .rd_b_data     (rd_b_data),
      .iss_valid     (iss_valid),
      .iss_we        (iss_we),
      .iss_dest      (iss_dest),
      .stall         (stall),
      .busy_vec      (busy_vec),
      .err_underflow (err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_read(input logic [2:0] adr);
      if (adr == 0) return 0;
      if (wb_we && wb_dest == adr) return int'(wb_result);
      return m_reg[adr];
   endfunction

   // Outstanding writes to r still visible to a reader this cycle.
   function automatic int m_eff(input logic [2:0] r);
      int e;
      e = m_pend[r] - ((wb_we && wb_dest == r) ? 1 : 0);
      return (e < 0) ? 0 : e;
   endfunction

   function automatic bit m_stall();
      bit hz;
      if (!iss_valid) return 1'b0;
      hz = 1'b0;
      if (rd_a_en && rd_a_adr != 0 && m_eff(rd_a_adr) > 0) hz = 1'b1;
      if (rd_b_en && rd_b_adr != 0 && m_eff(rd_b_adr) > 0) hz = 1'b1;
      if (iss_we && iss_dest != 0 && m_pend[iss_dest] == 3 &&
          !(wb_we && wb_dest == iss_dest)) hz = 1'b1;
      return hz;
   endfunction

   function automatic logic [7:0] m_busy();
      logic [7:0] b;
      b = '0;
      for (int r = 1; r < 8; r++) b[r] = (m_pend[r] != 0);
      return b;
   endfunction

   task automatic m_clear();
      for (int r = 0; r < 8; r++) begin
         m_reg[r]  = 0;
         m_pend[r] = 0;
      end
      m_err = 1'b0;
   endtask

   task automatic idle();
      wb_we = 0; wb_dest = 0; wb_result = 0;
      rd_a_adr = 0; rd_b_adr = 0; rd_a_en = 0; rd_b_en = 0;
      iss_valid = 0; iss_we = 0; iss_dest = 0;
   endtask

   // Compare combinational outputs, clock once, update the model, compare state.
   task automatic step();
      bit st;
      bit ins;
      bit wbk;
      #1;
      st = m_stall();
      chk("rd_a_data", rd_a_data, m_read(rd_a_adr));
      chk("rd_b_data", rd_b_data, m_read(rd_b_adr));
      chk("stall", stall, st);
      @(posedge clk);
      for (int r = 1; r < 8; r++) begin
         ins = iss_valid && iss_we && !st && iss_dest == r;
         wbk = wb_we && wb_dest == r;
         if (ins && !wbk) m_pend[r]++;
         else if (wbk && !ins) begin
            if (m_pend[r] > 0) m_pend[r]--;
            else m_err = 1'b1;
         end
      end
      if (wb_we && wb_dest != 0) m_reg[wb_dest] = int'(wb_result);
      #1;
      chk("busy_vec", busy_vec, m_busy());
      chk("err_underflow", err_underflow, m_err);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      #1;
      m_clear();
      chk("rst_busy", busy_vec, 8'h00);
      chk("rst_err", err_underflow, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b0;
      idle();
      m_clear();
      #2;
      do_reset();

      // Reset state over every address pair.
      for (int a = 0; a < 8; a++) begin
         rd_a_adr = 3'(a); rd_b_adr = 3'(7 - a); rd_a_en = 1; rd_b_en = 1;
         iss_valid = 1; iss_we = 1; iss_dest = 3'(a);
         #1;
         chk("reset_rd_a", rd_a_data, 8'h00);
         chk("reset_rd_b", rd_b_data, 8'h00);
         chk("reset_stall", stall, 1'b0);
         iss_valid = 0;
      end
      idle();
      step();

      // RAW hazard on R3, cleared by a same-cycle writeback through the bypass.
      iss_valid = 1; iss_we = 1; iss_dest = 3;
      step();
      chk("r3_busy", busy_vec[3], 1'b1);
      iss_dest = 1; rd_a_adr = 3; rd_a_en = 1;
      #1 chk("raw_stall", stall, 1'b1);
      wb_we = 1; wb_dest = 3; wb_result = 8'h5A;
      #1 chk("raw_bypass_stall", stall, 1'b0);
      chk("raw_bypass_data", rd_a_data, 8'h5A);
      step();
      chk("r3_cleared", busy_vec[3], 1'b0);
      idle();
      iss_valid = 1; iss_we = 0; iss_dest = 1;
      wb_we = 1; wb_dest = 1; wb_result = 8'h11;
      step();
      idle();

      // Three writes to R5 outstanding, then the fourth is blocked.
      iss_valid = 1; iss_we = 1; iss_dest = 5;
      repeat (3) step();
      chk("r5_busy", busy_vec[5], 1'b1);
      #1 chk("r5_full_stall", stall, 1'b1);
      wb_we = 1; wb_dest = 5; wb_result = 8'hC3;
      #1 chk("r5_full_wb_stall", stall, 1'b0);
      step();
      idle();
      iss_valid = 1; iss_we = 1; iss_dest = 5;
      #1 chk("r5_still_full", stall, 1'b1);
      idle();
      for (int k = 0; k < 3; k++) begin
         wb_we = 1; wb_dest = 5; wb_result = 8'(k + 1);
         step();
      end
      chk("r5_drained", busy_vec[5], 1'b0);
      chk("r5_no_err", err_underflow, 1'b0);

      // Writes to R0 are dropped and untracked.
      idle();
      wb_we = 1; wb_dest = 0; wb_result = 8'hFF;
      rd_a_adr = 0; rd_a_en = 1;
      iss_valid = 1; iss_we = 1; iss_dest = 0;
      #1 chk("r0_read", rd_a_data, 8'h00);
      chk("r0_stall", stall, 1'b0);
      step();
      chk("r0_busy", busy_vec, 8'h00);
      chk("r0_err", err_underflow, 1'b0);

      // Underflow on R6 is sticky and the data still lands.
      idle();
      wb_we = 1; wb_dest = 6; wb_result = 8'h77;
      step();
      chk("uflow_set", err_underflow, 1'b1);
      idle();
      rd_a_adr = 6; rd_a_en = 1;
      iss_valid = 1; iss_we = 1; iss_dest = 2;
      step();
      chk("r6_value", rd_a_data, 8'h77);
      wb_we = 1; wb_dest = 2; wb_result = 8'h22; iss_valid = 0;
      step();
      chk("uflow_sticky", err_underflow, 1'b1);

      // Reset mid-operation discards pending state.
      idle();
      iss_valid = 1; iss_we = 1; iss_dest = 2;
      step();
      chk("r2_busy", busy_vec[2], 1'b1);
      do_reset();
      rd_a_adr = 2; rd_a_en = 1;
      #1 chk("r2_after_rst", rd_a_data, 8'h00);
      chk("busy_after_rst", busy_vec, 8'h00);
      wb_we = 1; wb_dest = 2; wb_result = 8'h99;
      step();
      chk("late_wb_uflow", err_underflow, 1'b1);

      // Random traffic with occasional resets.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end
         wb_we     = ($urandom_range(0, 2) == 0);
         wb_dest   = 3'($urandom_range(0, 7));
         wb_result = 8'($urandom);
         rd_a_adr  = 3'($urandom_range(0, 7));
         rd_b_adr  = 3'($urandom_range(0, 7));
         rd_a_en   = ($urandom_range(0, 3) != 0);
         rd_b_en   = ($urandom_range(0, 1) != 0);
         iss_valid = ($urandom_range(0, 3) != 0);
         iss_we    = ($urandom_range(0, 3) != 0);
         iss_dest  = 3'($urandom_range(0, 7));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
